constraint_solution_gen: RTL and testbench

- Sequential generator for the shift-OR constraint form used by the split constraint checkers: constraint = |(v >> SHIFT).
- Where a checker takes a value and reports whether the constraint holds, this block goes the other way. It enumerates every WIDTH-bit value once and emits each value whose constraint result equals a requested target.
- Output is a valid/ready stream. It feeds solver test harnesses and BDD cross-checks with exact solution sets and counts.

---
 rtl/constraint_solution_gen.sv | 207 ++++++++++++++++++++
 tb/tb_constraint_solution_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/constraint_solution_gen.sv
// ---------------------------------------------------------------------------
// constraint_solution_gen
//
// Purpose:
//   Enumerates every WIDTH-bit value exactly once and streams out each value
//   whose shift-OR constraint result |(v >> SHIFT) equals the requested
//   target. Solution sets and counts feed solver harnesses and BDD checks.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a run (only honoured while idle)
//   want_sat   target constraint value, captured on an accepted start
//   rand_mode  0 = ascending order, 1 = LFSR order, captured on start
//   abort      terminate the current run without a done pulse
//   out_valid  out_value holds a matching candidate
//   out_ready  consumer accepts out_value
//   out_value  matching candidate
//   busy       generator is not idle
//   done       one-cycle pulse at the end of a complete run
//   sol_count  solutions handed off in the current/last run
//
// Configuration:
//   CSG_RANDOM_ORDER_EN - when defined, rand_mode selects a maximal-length
//   Fibonacci LFSR visiting order. When undefined there is no LFSR,
//   rand_mode is ignored and LFSR_SEED is unused.
// ---------------------------------------------------------------------------
module constraint_solution_gen #(
    parameter int WIDTH     = 8,
    parameter int SHIFT     = 3,
    parameter int LFSR_SEED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             want_sat,
    input  logic             rand_mode,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sol_count
);

    typedef enum logic [1:0] {IDLE, SEARCH, PRESENT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] candidate_q, candidate_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] outValue_q, outValue_d;
    logic [WIDTH:0]   solCount_q, solCount_d;
    logic             wantSat_q, wantSat_d;
    logic             hit;
    logic             lastStep;
    logic [WIDTH-1:0] candAdv;

`ifdef CSG_RANDOM_ORDER_EN
    // Feedback taps for a maximal-length sequence, one polynomial per width.
    // Bit k-1 of the mask corresponds to tap k of the shift register.
    function automatic logic [15:0] tapMask(input int w);
        case (w)
            2:       tapMask = 16'h0003;
            3:       tapMask = 16'h0006;
            4:       tapMask = 16'h000C;
            5:       tapMask = 16'h0014;
            6:       tapMask = 16'h0030;
            7:       tapMask = 16'h0060;
            8:       tapMask = 16'h00B8;
            9:       tapMask = 16'h0110;
            10:      tapMask = 16'h0240;
            11:      tapMask = 16'h0500;
            12:      tapMask = 16'h0829;
            13:      tapMask = 16'h100D;
            14:      tapMask = 16'h2015;
            15:      tapMask = 16'h6000;
            16:      tapMask = 16'hD008;
            default: tapMask = 16'h0003;
        endcase
    endfunction

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(tapMask(WIDTH));
    localparam logic [WIDTH-1:0] SEED = WIDTH'(LFSR_SEED);

    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] lfsrNext;
    logic             randMode_q, randMode_d;

    assign lfsrNext = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    // In LFSR order candidate 0 comes first, then the LFSR walks all
    // nonzero values, so the register's current state is the next candidate.
    assign candAdv  = randMode_q ? lfsr_q : candidate_q + 1'b1;
`else
    logic             unused_rand_mode;
    logic [WIDTH-1:0] unused_seed;

    assign unused_rand_mode = rand_mode;
    assign unused_seed      = WIDTH'(LFSR_SEED);
    assign candAdv          = candidate_q + 1'b1;
`endif

    assign hit      = ((|(candidate_q >> SHIFT)) == wantSat_q);
    assign lastStep = &step_q;

    // Next-state logic; abort is applied last so it overrides every other
    // transition, including a same-cycle handshake.
    always_comb begin
        state_d     = state_q;
        candidate_d = candidate_q;
        step_d      = step_q;
        outValue_d  = outValue_q;
        solCount_d  = solCount_q;
        wantSat_d   = wantSat_q;
`ifdef CSG_RANDOM_ORDER_EN
        lfsr_d      = lfsr_q;
        randMode_d  = randMode_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    wantSat_d   = want_sat;
                    solCount_d  = '0;
                    candidate_d = '0;
                    step_d      = '0;
`ifdef CSG_RANDOM_ORDER_EN
                    randMode_d  = rand_mode;
                    lfsr_d      = SEED;
`endif
                    state_d     = SEARCH;
                end
            end
            SEARCH: begin
                if (hit) begin
                    outValue_d = candidate_q;
                    state_d    = PRESENT;
                end else if (lastStep) begin
                    state_d = DONE;
                end else begin
                    step_d      = step_q + 1'b1;
                    candidate_d = candAdv;
`ifdef CSG_RANDOM_ORDER_EN
                    if (randMode_q) lfsr_d = lfsrNext;
`endif
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    solCount_d = solCount_q + 1'b1;
                    if (lastStep) begin
                        state_d = DONE;
                    end else begin
                        step_d      = step_q + 1'b1;
                        candidate_d = candAdv;
`ifdef CSG_RANDOM_ORDER_EN
                        if (randMode_q) lfsr_d = lfsrNext;
`endif
                        state_d     = SEARCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            solCount_d = solCount_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            candidate_q <= '0;
            step_q      <= '0;
            outValue_q  <= '0;
            solCount_q  <= '0;
            wantSat_q   <= 1'b0;
`ifdef CSG_RANDOM_ORDER_EN
            lfsr_q      <= SEED;
            randMode_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            candidate_q <= candidate_d;
            step_q      <= step_d;
            outValue_q  <= outValue_d;
            solCount_q  <= solCount_d;
            wantSat_q   <= wantSat_d;
`ifdef CSG_RANDOM_ORDER_EN
            lfsr_q      <= lfsr_d;
            randMode_q  <= randMode_d;
`endif
        end
    end

    assign out_valid = (state_q == PRESENT);
    assign out_value = outValue_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign sol_count = solCount_q;

endmodule

// File: tb/tb_constraint_solution_gen.sv
// ---------------------------------------------------------------------------
// tb_constraint_solution_gen
//
// Purpose:
//   Self-checking bench for constraint_solution_gen. Two instances share the
//   clock and reset: SHIFT=3 (dutA) and SHIFT=8 (dutB, constant-0 case).
//   A table of runs is applied with random consumer back-pressure; emitted
//   values are compared against a reference solution set computed directly
//   from the constraint rule. Abort and mid-run reset are hand sequences.
//   Define CSG_RANDOM_ORDER_EN to also exercise the LFSR ordering.
// ---------------------------------------------------------------------------
module tb_constraint_solution_gen;

    localparam int W = 8;

    typedef struct {
        bit want;
        bit rmode;
        bit randReady;
        int shift;
        int expLatency;
        int expCount;
        bit cmpPrev;
    } runVec_t;

`ifdef CSG_RANDOM_ORDER_EN
    localparam bit RAND_EN = 1'b1;
`else
    localparam bit RAND_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         startSig = 1'b0;
    logic         abortSig = 1'b0;
    logic         wantSat = 1'b0;
    logic         randMode = 1'b0;
    logic         outReady = 1'b1;
    logic         sel = 1'b0;

    logic         aValid, aBusy, aDone;
    logic [W-1:0] aValue;
    logic [W:0]   aCount;
    logic         bValid, bBusy, bDone;
    logic [W-1:0] bValue;
    logic [W:0]   bCount;

    logic         obsValid, obsBusy, obsDone;
    logic [W-1:0] obsValue;
    logic [W:0]   obsCount;

    int total = 0;
    int bad   = 0;
    int got[$];
    int prevSeq[$];

    always #5 clk = ~clk;

    constraint_solution_gen #(.WIDTH(W), .SHIFT(3), .LFSR_SEED(1)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startSig & ~sel), .want_sat(wantSat),
        .rand_mode(randMode), .abort(abortSig & ~sel), .out_valid(aValid),
        .out_ready(outReady), .out_value(aValue), .busy(aBusy), .done(aDone),
        .sol_count(aCount)
    );

    constraint_solution_gen #(.WIDTH(W), .SHIFT(8), .LFSR_SEED(1)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startSig & sel), .want_sat(wantSat),
        .rand_mode(randMode), .abort(abortSig & sel), .out_valid(bValid),
        .out_ready(outReady), .out_value(bValue), .busy(bBusy), .done(bDone),
        .sol_count(bCount)
    );

    assign obsValid = sel ? bValid : aValid;
    assign obsBusy  = sel ? bBusy  : aBusy;
    assign obsDone  = sel ? bDone  : aDone;
    assign obsValue = sel ? bValue : aValue;
    assign obsCount = sel ? bCount : aCount;

    // Reference rule: a value is a solution when its shifted image is
    // nonzero exactly when the target is 1.
    function automatic bit satisfies(int v, int shift, bit want);
        return ((v >> shift) != 0) == want;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drives one run to completion and records every handed-off value.
    task automatic applyStimulus(input runVec_t v, output int latency,
                                 output int doneCnt, output int stableErr,
                                 output bit timedOut);
        int  n;
        bit  prevHold;
        int  prevVal;
        got.delete();
        latency   = -1;
        doneCnt   = 0;
        stableErr = 0;
        timedOut  = 1'b0;
        prevHold  = 1'b0;
        prevVal   = 0;
        n         = 0;
        @(negedge clk);
        sel      = (v.shift == 8);
        wantSat  = v.want;
        randMode = v.rmode;
        outReady = 1'b1;
        startSig = 1'b1;
        forever begin
            @(posedge clk);
            n++;
            @(negedge clk);
            startSig = 1'b0;
            if (obsValid && latency < 0) latency = n;
            if (prevHold && (!obsValid || int'(obsValue) != prevVal)) stableErr++;
            if (obsDone) doneCnt++;
            if (!obsBusy) break;
            if (n > 3000) begin
                timedOut = 1'b1;
                break;
            end
            outReady = v.randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (obsValid && outReady) got.push_back(int'(obsValue));
            prevHold = obsValid && !outReady;
            prevVal  = int'(obsValue);
            if (v.randReady) startSig = 1'($urandom_range(0, 7) == 0);
        end
        startSig = 1'b0;
        outReady = 1'b1;
    endtask

    task automatic checkRun(input runVec_t v, input int idx);
        int  latency, doneCnt, stableErr;
        bit  timedOut;
        int  model[$];
        bit  seen[256];
        int  memberErr, orderErr, prevErr;
        bit  ascOrder;
        applyStimulus(v, latency, doneCnt, stableErr, timedOut);
        for (int x = 0; x < (1 << W); x++)
            if (satisfies(x, v.shift, v.want)) model.push_back(x);
        for (int x = 0; x < 256; x++) seen[x] = 1'b0;
        memberErr = 0;
        foreach (got[i]) begin
            if (!satisfies(got[i], v.shift, v.want) || seen[got[i]]) memberErr++;
            seen[got[i]] = 1'b1;
        end
        orderErr = (got.size() == model.size()) ? 0 : 1;
        if (orderErr == 0)
            foreach (got[i]) if (got[i] != model[i]) orderErr++;
        ascOrder = (orderErr == 0);
        checkOutput($sformatf("run%0d_timeout", idx), int'(timedOut), 0);
        checkOutput($sformatf("run%0d_emitted", idx), got.size(), v.expCount);
        checkOutput($sformatf("run%0d_solCount", idx), int'(obsCount), v.expCount);
        checkOutput($sformatf("run%0d_donePulses", idx), doneCnt, 1);
        checkOutput($sformatf("run%0d_stableErr", idx), stableErr, 0);
        checkOutput($sformatf("run%0d_setErr", idx), memberErr, 0);
        if (v.expLatency >= 0)
            checkOutput($sformatf("run%0d_latency", idx), latency, v.expLatency);
        if (v.rmode && RAND_EN) begin
            if (v.want) checkOutput($sformatf("run%0d_lfsrAscending", idx), int'(ascOrder), 0);
            if (v.cmpPrev) begin
                prevErr = (got.size() == prevSeq.size()) ? 0 : 1;
                if (prevErr == 0)
                    foreach (got[i]) if (got[i] != prevSeq[i]) prevErr++;
                checkOutput($sformatf("run%0d_repeatErr", idx), prevErr, 0);
            end
        end else begin
            checkOutput($sformatf("run%0d_orderErr", idx), orderErr, 0);
        end
        prevSeq = got;
    endtask

    initial begin
        runVec_t rows[8];
        int      presentSeen;
        int      doneSeen;
        bit      aborted;

        rows[0] = '{1'b0, 1'b0, 1'b0, 3, 2,  8,   1'b0};
        rows[1] = '{1'b1, 1'b0, 1'b0, 3, 10, 248, 1'b0};
        rows[2] = '{1'b1, 1'b0, 1'b1, 3, -1, 248, 1'b0};
        rows[3] = '{1'b0, 1'b1, 1'b1, 3, 2,  8,   1'b0};
        rows[4] = '{1'b1, 1'b1, 1'b0, 3, -1, 248, 1'b0};
        rows[5] = '{1'b1, 1'b1, 1'b0, 3, -1, 248, 1'b1};
        rows[6] = '{1'b0, 1'b0, 1'b1, 8, 2,  256, 1'b0};
        rows[7] = '{1'b1, 1'b0, 1'b0, 8, -1, 0,   1'b0};

        #2;
        checkOutput("reset_busy",  int'(aBusy),  0);
        checkOutput("reset_valid", int'(aValid), 0);
        checkOutput("reset_done",  int'(aDone),  0);
        checkOutput("reset_count", int'(aCount), 0);
        checkOutput("reset_value", int'(aValue), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 8; r++) checkRun(rows[r], r);

        // Abort on the third presented value: two handshakes count, the
        // third (same cycle as abort) does not.
        @(negedge clk);
        sel = 1'b0; wantSat = 1'b0; randMode = 1'b0; outReady = 1'b1;
        startSig = 1'b1;
        presentSeen = 0;
        aborted = 1'b0;
        for (int c = 0; c < 50 && !aborted; c++) begin
            @(posedge clk);
            @(negedge clk);
            startSig = 1'b0;
            if (aValid) presentSeen++;
            if (presentSeen == 3) begin
                abortSig = 1'b1;
                aborted  = 1'b1;
            end
        end
        checkOutput("abort_reached", int'(aborted), 1);
        @(posedge clk);
        @(negedge clk);
        abortSig = 1'b0;
        checkOutput("abort_busy",  int'(aBusy),  0);
        checkOutput("abort_valid", int'(aValid), 0);
        checkOutput("abort_count", int'(aCount), 2);
        doneSeen = int'(aDone);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (aDone) doneSeen++;
        end
        checkOutput("abort_noDone", doneSeen, 0);
        checkRun(rows[0], 10);

        // Reset between clock edges while searching for want_sat=1 values.
        @(negedge clk);
        sel = 1'b0; wantSat = 1'b1; randMode = 1'b0;
        startSig = 1'b1;
        @(posedge clk);
        @(negedge clk);
        startSig = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midReset_busy",  int'(aBusy),  0);
        checkOutput("midReset_valid", int'(aValid), 0);
        checkOutput("midReset_done",  int'(aDone),  0);
        checkOutput("midReset_count", int'(aCount), 0);
        checkOutput("midReset_value", int'(aValue), 0);
        @(negedge clk);
        rst_n = 1'b1;
        checkRun(rows[1], 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
